// File: rtl/imem_pkg.sv
// Shared definitions for the fetch-stage instruction memory responder.
package imem_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWait  = 2'd1,
        StDrive = 2'd2
    } state_e;

    localparam logic [31:0] NOP_INST_WORD     = 32'h0000_0013;
    localparam int unsigned FETCH_DEPTH       = 1024;
    localparam int unsigned FETCH_WAIT_CYCLES = 2;

endpackage

// File: rtl/imem_array.sv
// Single-clock instruction RAM: synchronous preload write, synchronous read.
module imem_array
    import imem_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = FETCH_DEPTH,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Non-blocking update gives read-before-write when both hit the same word.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: samples a fetch request, waits WAIT_CYCLES,
// then presents the word on instout with a one-cycle MDR_wr strobe.
module imem_responder
    import imem_pkg::*;
#(
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       DEPTH       = FETCH_DEPTH,
    parameter int unsigned       ADDR_W      = 10,
    parameter int unsigned       WAIT_CYCLES = FETCH_WAIT_CYCLES,
    parameter logic [DATA_W-1:0] NOP_INST    = DATA_W'(NOP_INST_WORD)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [31:0]       addr,
    output logic              busy,
    output logic [DATA_W-1:0] instout,
    output logic              MDR_wr,
    output logic              err,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data
);

    localparam logic [31:0] DepthLim = 32'(DEPTH);
    localparam logic [3:0]  WaitLoad = 4'(WAIT_CYCLES);

    state_e            r_state, w_state_d;
    logic [3:0]        r_cnt, w_cnt_d;
    logic              r_req;
    logic [31:0]       r_addr;
    logic              r_err_pend, w_err_pend_d;
    logic              r_out_valid;
    logic              r_out_nop;
    logic              w_addr_err;
    logic              w_sample;
    logic              w_drive_entry;
    logic              w_rd_en;
    logic [DATA_W-1:0] w_rdata;

    assign w_addr_err = (r_addr[1:0] != 2'b00) || ({2'b00, r_addr[31:2]} >= DepthLim);

    // req/addr are captured only on edges that land in IDLE; the FSM acts on them next edge.
    assign w_sample      = req && (w_state_d == StIdle);
    assign w_drive_entry = (w_state_d == StDrive) && (r_state != StDrive);
    assign w_rd_en       = w_drive_entry && !w_err_pend_d;

    always_comb begin
        w_state_d    = r_state;
        w_cnt_d      = r_cnt;
        w_err_pend_d = r_err_pend;
        case (r_state)
            StIdle: begin
                if (r_req) begin
                    w_err_pend_d = w_addr_err;
                    if (WAIT_CYCLES == 0) begin
                        w_state_d = StDrive;
                    end else begin
                        w_state_d = StWait;
                        w_cnt_d   = WaitLoad;
                    end
                end
            end
            StWait: begin
                w_cnt_d = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_d = StDrive;
                end
            end
            StDrive: begin
                w_state_d    = StIdle;
                w_err_pend_d = 1'b0;
            end
            default: begin
                w_state_d    = StIdle;
                w_err_pend_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_cnt       <= 4'd0;
            r_req       <= 1'b0;
            r_addr      <= 32'd0;
            r_err_pend  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_nop   <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_cnt      <= w_cnt_d;
            r_err_pend <= w_err_pend_d;
            r_req      <= w_sample;
            if (w_sample) begin
                r_addr <= addr;
            end
            if (w_drive_entry) begin
                r_out_valid <= 1'b1;
                r_out_nop   <= w_err_pend_d;
            end
        end
    end

    imem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .i_clk   (clk),
        .i_we    (load_en),
        .i_waddr (load_addr),
        .i_wdata (load_data),
        .i_re    (w_rd_en),
        .i_raddr (r_addr[ADDR_W+1:2]),
        .o_rdata (w_rdata)
    );

    // Array output is not reset, so the visible word is gated until the first response.
    always_comb begin
        instout = '0;
        if (r_out_valid) begin
            instout = r_out_nop ? NOP_INST : w_rdata;
        end
    end

    assign busy   = (r_state != StIdle);
    assign MDR_wr = (r_state == StDrive);
    assign err    = MDR_wr && r_err_pend;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: directed cases plus randomized requests and preloads,
// checked against an array model and the request-to-response latency rule.
module tb_imem_responder;

    localparam int          W   = 2;
    localparam int          DRV = W + 1;   // edge after the request edge that enters DRIVE
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, req0;
    logic [31:0] addr, addr0;
    logic        load_en;
    logic [9:0]  load_addr;
    logic [31:0] load_data;
    logic        busy, mdr_wr, err;
    logic [31:0] instout;
    logic        busy0, mdr_wr0, err0;
    logic [31:0] instout0;

    logic [31:0] ref_mem [1024];
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    imem_responder #(
        .DATA_W      (32),
        .DEPTH       (1024),
        .ADDR_W      (10),
        .WAIT_CYCLES (W),
        .NOP_INST    (NOP)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .addr      (addr),
        .busy      (busy),
        .instout   (instout),
        .MDR_wr    (mdr_wr),
        .err       (err),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data)
    );

    imem_responder #(
        .DATA_W      (32),
        .DEPTH       (1024),
        .ADDR_W      (10),
        .WAIT_CYCLES (0),
        .NOP_INST    (NOP)
    ) u_dut0 (
        .clk       (clk),
        .rst       (rst),
        .req       (req0),
        .addr      (addr0),
        .busy      (busy0),
        .instout   (instout0),
        .MDR_wr    (mdr_wr0),
        .err       (err0),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic is_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:2] >= 30'd1024);
    endfunction

    // One request issued on edge 0, optional preload applied on edge ld_edge.
    task automatic txn(input logic [31:0] a, input bit do_ld, input int ld_edge,
                       input logic [9:0] ld_idx, input logic [31:0] ld_data, input string tag);
        logic        e_bad;
        logic [31:0] e_word;
        e_bad  = is_bad(a);
        e_word = NOP;
        for (int e = 0; e <= DRV + 1; e++) begin
            req       = (e == 0);
            addr      = a;
            load_en   = do_ld && (e == ld_edge);
            load_addr = ld_idx;
            load_data = ld_data;
            if (e == DRV && !e_bad) e_word = ref_mem[a[11:2]];
            if (do_ld && e == ld_edge) ref_mem[ld_idx] = ld_data;
            step();
            check({tag, ".busy"}, 32'(busy), 32'(e >= 1 && e <= DRV));
            check({tag, ".mdr"}, 32'(mdr_wr), 32'(e == DRV));
            check({tag, ".err"}, 32'(err), 32'(e == DRV && e_bad));
            if (e >= DRV) check({tag, ".inst"}, instout, e_word);
        end
        req     = 1'b0;
        load_en = 1'b0;
    endtask

    initial begin
        int          n_pulse;
        logic [31:0] a;
        logic [9:0]  li;
        bit          dl;
        int          le;

        rst       = 1'b1;
        req       = 1'b0;
        req0      = 1'b0;
        addr      = 32'd0;
        addr0     = 32'd0;
        load_en   = 1'b0;
        load_addr = 10'd0;
        load_data = 32'd0;

        step();
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.mdr", 32'(mdr_wr), 32'd0);
        check("rst.err", 32'(err), 32'd0);
        check("rst.inst", instout, 32'd0);

        // Fill both memories through the shared preload port while in reset.
        for (int i = 0; i < 1024; i++) begin
            ref_mem[i] = $urandom;
            if (i == 0) ref_mem[i] = 32'h0000_0001;
            if (i == 1) ref_mem[i] = 32'h0000_0005;
            if (i == 4) ref_mem[i] = 32'hDEAD_BEEF;
            if (i == 8) ref_mem[i] = 32'hAAAA_0000;
            load_en   = 1'b1;
            load_addr = 10'(i);
            load_data = ref_mem[i];
            step();
        end
        load_en = 1'b0;
        rst     = 1'b0;
        step();

        // Zero-wait build: response after edge 1, next request sampled on edge 2.
        req0  = 1'b1;
        addr0 = 32'h4;
        step();
        req0 = 1'b0;
        step();
        check("w0.mdr1", 32'(mdr_wr0), 32'd1);
        check("w0.inst1", instout0, 32'h0000_0005);
        check("w0.err1", 32'(err0), 32'd0);
        req0  = 1'b1;
        addr0 = 32'h10;
        step();
        req0 = 1'b0;
        check("w0.mdr2", 32'(mdr_wr0), 32'd0);
        step();
        check("w0.mdr3", 32'(mdr_wr0), 32'd1);
        check("w0.inst3", instout0, 32'hDEAD_BEEF);
        step();

        txn(32'h10, 1'b0, 0, 10'd0, 32'd0, "basic");
        check("basic.const", instout, 32'hDEAD_BEEF);
        txn(32'h11, 1'b0, 0, 10'd0, 32'd0, "misal");
        txn(32'h1000, 1'b0, 0, 10'd0, 32'd0, "range");
        txn(32'hFFC, 1'b0, 0, 10'd0, 32'd0, "last");

        // Request held high: one response every W+2 cycles, nothing extra.
        n_pulse = 0;
        for (int e = 0; e <= 12; e++) begin
            req  = (e <= 11);
            addr = 32'h0;
            step();
            check("held.mdr", 32'(mdr_wr), 32'(e >= DRV && ((e - DRV) % (W + 2)) == 0));
            if (mdr_wr) begin
                n_pulse++;
                check("held.inst", instout, 32'h0000_0001);
            end
        end
        req = 1'b0;
        check("held.count", 32'(n_pulse), 32'd3);
        step();

        // Reset during WAIT aborts the request.
        req  = 1'b1;
        addr = 32'h10;
        step();
        req = 1'b0;
        step();
        step();
        rst = 1'b1;
        #1;
        check("mrst.busy", 32'(busy), 32'd0);
        check("mrst.mdr", 32'(mdr_wr), 32'd0);
        check("mrst.err", 32'(err), 32'd0);
        check("mrst.inst", instout, 32'd0);
        check("mrst.inst0", instout0, 32'd0);
        step();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            check("mrst.quiet", 32'({busy, mdr_wr}), 32'd0);
        end
        txn(32'h10, 1'b0, 0, 10'd0, 32'd0, "after_rst");

        // Preload one edge before DRIVE entry is seen; on the entry edge it is not.
        txn(32'h20, 1'b1, DRV - 1, 10'd8, 32'hBBBB_0000, "race_early");
        check("race_early.const", instout, 32'hBBBB_0000);
        load_en   = 1'b1;
        load_addr = 10'd8;
        load_data = 32'hAAAA_0000;
        ref_mem[8] = 32'hAAAA_0000;
        step();
        load_en = 1'b0;
        txn(32'h20, 1'b1, DRV, 10'd8, 32'hBBBB_0000, "race_same");
        check("race_same.const", instout, 32'hAAAA_0000);

        for (int t = 0; t < 24; t++) begin
            case ($urandom_range(0, 3))
                0, 1:    a = {20'd0, 10'($urandom), 2'b00};
                2:       a = {20'd0, 10'($urandom), 2'($urandom_range(1, 3))};
                default: a = $urandom | 32'h0000_1000;
            endcase
            dl = 1'($urandom_range(0, 1));
            le = int'($urandom_range(0, DRV + 1));
            li = ($urandom_range(0, 1) == 1) ? a[11:2] : 10'($urandom);
            txn(a, dl, le, li, $urandom, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
Instruction-memory responder on the fetch-stage memory interface; it is the producer that feeds the memory data register. It accepts a read request carrying a byte address from the fetch address path, waits a configurable number of memory wait states, then presents the instruction word on instout with a one-cycle MDR_wr strobe. It also provides a preload port for filling the instruction memory before or during a run.

Parameters:
DATA_W, 32, instruction word width
DEPTH, 1024, number of words in instruction memory
ADDR_W, 10, word-index width, equal to clog2(DEPTH)
WAIT_CYCLES, 2, memory wait states between request acceptance and response, range 0..15
NOP_INST, 32'h00000013, word returned on an erroneous access

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
req  input  1  read request, sampled only in IDLE
addr  input  32  byte address of the requested instruction
busy  output  1  high while a request is in flight, through the response cycle inclusive
instout  output  DATA_W  response word, connects to MDR instin
MDR_wr  output  1  one-cycle strobe meaning instout is valid; MDR captures on it
err  output  1  high only with MDR_wr when the access was misaligned or out of range
load_en  input  1  preload write enable
load_addr  input  ADDR_W  preload word index
load_data  input  DATA_W  preload data

Behaviour:
- Reset (asynchronous, any state): state goes to IDLE; busy, MDR_wr and err go to 0; instout goes to 0; the wait counter goes to 0. Memory contents are not reset. A reset mid-request aborts the request with no MDR_wr pulse.
- FSM states:
  - IDLE, busy=0.
  - WAIT, busy=1, counting down.
  - DRIVE, busy=1, MDR_wr=1 for exactly one cycle.
- Accept: req=1 on edge N while in IDLE latches addr.
  - Error check: addr[1:0]!=0, or addr[31:2]>=DEPTH, sets the pending-error flag.
  - If WAIT_CYCLES=0, the next state is DRIVE. Otherwise the next state is WAIT and the counter loads WAIT_CYCLES.
- WAIT: the counter decrements each edge. When it equals 1, the next state is DRIVE.
- Latency: for req sampled on edge N, MDR_wr is high in the cycle following edge N+1+WAIT_CYCLES. The edge that enters DRIVE also registers instout.
- DRIVE to IDLE unconditionally after one cycle.
  - req is ignored in WAIT and DRIVE; there is no queueing. The requester must re-assert after busy falls.
  - Back-to-back throughput is therefore one response per WAIT_CYCLES+2 cycles.
- Read data:
  - Normal access: instout = mem[addr[ADDR_W+1:2]] and err=1'b0.
  - Error access: instout = NOP_INST and err=1; memory is not read.
- instout holds its value after DRIVE until the next response or reset. err clears to 0 when leaving DRIVE.
- Preload: load_en writes mem[load_addr] on the rising edge, in any state.
  - A write on an edge before the DRIVE-entry edge is visible to the pending read.
  - A write on the same edge as the DRIVE-entry read returns the old data (read-before-write).
- Width rules: the word index is addr[ADDR_W+1:2]. The upper address bits are used only for the range check. The counter is 4 bits wide.

Decomposition:
- Shared package (imem_pkg): state enum (IDLE, WAIT, DRIVE), NOP_INST constant, default DEPTH and WAIT_CYCLES constants for the fetch stage.
- Sub-module imem_array: single-clock RAM with a synchronous write port (load) and a synchronous read port, read-before-write on the same address. No reset.
- The FSM, counter and error check stay in imem_responder.

Test Plan:
- Basic read, WAIT_CYCLES=2: preload mem[4]=32'hDEADBEEF, reset, then pulse req with addr=32'h10 on edge 0.
  - Required: busy=1 from edge 1 through edge 3; MDR_wr=1 only after edge 3; instout=32'hDEADBEEF; err=0; busy=0 after edge 4.
- Misaligned access: req with addr=32'h11.
  - Required: MDR_wr pulse at the same latency; instout=32'h00000013; err=1 for that cycle only.
  - Repeat with addr=32'h1000 (index 1024, out of range) and require the same response.
- Request while busy: req held high continuously with addr=32'h0, mem[0]=32'h1.
  - Required: exactly one MDR_wr per 4 cycles (WAIT_CYCLES+2); no extra pulses; instout=32'h1 each time.
- Reset mid-operation: accept req, assert rst during WAIT.
  - Required: busy, MDR_wr, err and instout are 0 immediately, asynchronously; no MDR_wr pulse after rst deasserts; a later req completes normally.
- Preload race: read word 8, which holds 32'hAAAA0000.
  - Load 32'hBBBB0000 to word 8 one edge before the DRIVE-entry edge: the response is 32'hBBBB0000.
  - Load on the DRIVE-entry edge instead: the response is 32'hAAAA0000.
- WAIT_CYCLES=0 build: req on edge 0 with mem[1]=32'h5, addr=32'h4.
  - Required: MDR_wr high after edge 1 with instout=32'h5; the next request is accepted on edge 2.
